// File: rtl/rv_pkg.sv
// Shared RV32 constants and fetch-stage types used by the fetch/decode slice.
package rv_pkg;

    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/ifetch_pc_reg.sv
// Program counter with pending-redirect storage for killed in-flight fetches.
module ifetch_pc_reg
    import rv_pkg::*;
#(
    parameter int unsigned         XLEN     = 32,
    parameter logic [XLEN-1:0]     RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_inc,
    input  logic            load_target,
    input  logic            load_redirect,
    input  logic            set_kill,
    input  logic            clr_kill,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc,
    output logic            kill
);

    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] target_aligned;
    logic [XLEN-1:0] pc_next;

    assign target_aligned = target & ~XLEN'(3);

    // A fresh branch target outranks a stored redirect, which outranks sequential flow.
    always_comb begin
        pc_next = pc;
        if (load_target) begin
            pc_next = target_aligned;
        end else if (load_redirect) begin
            pc_next = redirect_pc;
        end else if (load_inc) begin
            pc_next = pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            redirect_pc <= '0;
            kill        <= 1'b0;
        end else begin
            pc <= pc_next;
            if (set_kill) begin
                redirect_pc <= target_aligned;
                kill        <= 1'b1;
            end else if (clr_kill) begin
                kill <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one outstanding imem request, instruction latch and valid/ready hand-off to decode.
module instruction_fetch_unit
    import rv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic            kill;
    logic            load_inc;
    logic            load_target;
    logic            load_redirect;
    logic            set_kill;
    logic            clr_kill;
    logic            latch_en;

    ifetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .load_inc      (load_inc),
        .load_target   (load_target),
        .load_redirect (load_redirect),
        .set_kill      (set_kill),
        .clr_kill      (clr_kill),
        .target        (branch_target),
        .pc            (pc),
        .kill          (kill)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  state_next = FETCH;
            FETCH: if (imem_gnt) state_next = WAIT;
            WAIT:  if (imem_rvalid) state_next = (kill || branch_taken) ? FETCH : HOLD;
            HOLD:  if (branch_taken || instr_ready) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // Redirects seen while a request is in flight are parked until its data returns.
    always_comb begin
        imem_req      = 1'b0;
        instr_valid   = 1'b0;
        load_inc      = 1'b0;
        load_target   = 1'b0;
        load_redirect = 1'b0;
        set_kill      = 1'b0;
        clr_kill      = 1'b0;
        latch_en      = 1'b0;
        unique case (state)
            FETCH: begin
                imem_req = 1'b1;
                set_kill = branch_taken;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    clr_kill = 1'b1;
                    if (branch_taken) begin
                        load_target = 1'b1;
                    end else if (kill) begin
                        load_redirect = 1'b1;
                    end else begin
                        latch_en = 1'b1;
                    end
                end else begin
                    set_kill = branch_taken;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (branch_taken) begin
                    load_target = 1'b1;
                end else if (instr_ready) begin
                    load_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr    <= XLEN'(NOP_INSTR);
            instr_pc <= RESET_PC;
        end else if (latch_en) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
        end
    end

    assign imem_addr = pc;
    assign opcode    = instr[6:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: transaction-level fetch model feeds expected queues, a negedge monitor checks them.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_instr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .opcode        (opcode),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    logic [31:0]  q_addr[$];
    exp_instr_t   q_instr[$];
    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;

    // Reference model: the fetch stream seen as transactions.
    bit          m_present;
    bit          m_kill;
    logic [31:0] m_ktgt;
    logic [31:0] m_fetch_pc;

    // Memory responder configuration (negative = random 0..2 cycles).
    bit          mem_busy;
    int          mem_cnt;
    int          gnt_cnt;
    int          gnt_fix;
    int          rv_fix;
    bit          spur_en;
    bit          rdata_fix_en;
    logic [31:0] rdata_fix;

    function automatic int pick(input int f);
        return (f >= 0) ? f : int'($urandom_range(2, 0));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [31:0] a);
        m_fetch_pc = a;
        q_addr.push_back(a);
    endtask

    task automatic model_step(input bit br, input logic [31:0] tgt, input bit rdy,
                              input bit rv, input logic [31:0] rd);
        if (m_present) begin
            if (br) begin
                if (!rdy) void'(q_instr.pop_front());
                m_present = 0;
                issue(tgt);
            end else if (rdy) begin
                m_present = 0;
                issue(m_fetch_pc + 32'd4);
            end
        end else if (rv) begin
            if (br) begin
                issue(tgt);
            end else if (m_kill) begin
                issue(m_ktgt);
            end else begin
                q_instr.push_back('{word: rd, pc: m_fetch_pc});
                m_present = 1;
            end
            m_kill = 0;
        end else if (br) begin
            m_kill = 1;
            m_ktgt = tgt;
        end
    endtask

    task automatic cycle(input bit br, input logic [31:0] tgt, input bit rdy);
        bit          rv;
        bit          spur;
        bit          was_busy;
        logic [31:0] rd;
        @(posedge clk);
        #1;
        rv       = 0;
        spur     = 0;
        was_busy = mem_busy;
        rd       = rdata_fix_en ? rdata_fix : $urandom;
        imem_gnt = 1'b0;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                rv       = 1;
                mem_busy = 0;
                gnt_cnt  = pick(gnt_fix);
            end else begin
                mem_cnt--;
            end
        end else if (imem_req) begin
            if (gnt_cnt == 0) begin
                imem_gnt = 1'b1;
                mem_busy = 1;
                mem_cnt  = pick(rv_fix);
            end else begin
                gnt_cnt--;
            end
        end
        if (spur_en && !was_busy && $urandom_range(5, 0) == 0) spur = 1;
        imem_rvalid   = rv | spur;
        imem_rdata    = rd;
        instr_ready   = rdy;
        branch_taken  = br;
        branch_target = tgt;
        model_step(br, tgt & 32'hFFFF_FFFC, rdy, rv, rd);
    endtask

    task automatic do_reset(input bit stale);
        reset         = 1'b0;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        q_addr.delete();
        q_instr.delete();
        m_present = 0;
        m_kill    = 0;
        mem_busy  = 0;
        mem_cnt   = 0;
        gnt_cnt   = pick(gnt_fix);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_instr_pc", instr_pc, RST_PC);
        chk("rst_opcode", opcode, 7'b0010011);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        if (stale) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        issue(RST_PC);
    endtask

    task automatic wait_present();
        int n = 0;
        while (!m_present && n < 20) begin
            cycle(0, '0, 0);
            n++;
        end
        chk("wait_present", m_present, 1);
    endtask

    always @(negedge clk) begin : monitor
        exp_instr_t e;
        if (reset === 1'b1) begin
            if (imem_req && imem_gnt) begin
                if (q_addr.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL addr_unexpected: got request at %h, expected none", imem_addr);
                end else begin
                    chk("imem_addr", imem_addr, q_addr.pop_front());
                end
            end
            if (instr_valid && instr_ready) begin
                if (q_instr.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL instr_unexpected: got %h @ %h, expected none", instr, instr_pc);
                end else begin
                    e = q_instr.pop_front();
                    chk("instr", instr, e.word);
                    chk("instr_pc", instr_pc, e.pc);
                    chk("opcode", {25'd0, opcode}, {25'd0, e.word[6:0]});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        gnt_fix      = 0;
        rv_fix       = 0;
        spur_en      = 0;
        rdata_fix_en = 1;
        rdata_fix    = 32'h00A0_0093;
        #2;

        // Zero-wait memory, ready tied high: one instruction every 3 cycles.
        do_reset(0);
        for (int n = 1; n <= 9; n++) begin
            cycle(0, '0, 1);
            chk("t1_req", imem_req, (n % 3 == 1));
            chk("t1_valid", instr_valid, (n % 3 == 0));
        end

        // Backpressure holds the instruction and blocks new requests.
        rdata_fix_en = 0;
        do_reset(0);
        wait_present();
        for (int n = 0; n < 4; n++) begin
            cycle(0, '0, 0);
            chk("t2_valid", instr_valid, 1);
            chk("t2_req", imem_req, 0);
            chk("t2_instr", instr, q_instr[0].word);
            chk("t2_instr_pc", instr_pc, q_instr[0].pc);
        end
        cycle(0, '0, 1);
        cycle(0, '0, 0);

        // Redirect during WAIT with late rvalid: data dropped, refetch at 0x100.
        rv_fix       = 3;
        rdata_fix_en = 1;
        rdata_fix    = 32'h0000_0033;
        do_reset(0);
        cycle(0, '0, 1);
        cycle(1, 32'h0000_0100, 1);
        chk("t3_valid", instr_valid, 0);
        for (int n = 0; n < 4; n++) begin
            cycle(0, '0, 1);
            chk("t3_valid", instr_valid, 0);
        end
        chk("t3_req", imem_req, 1);
        cycle(0, '0, 0);

        // Redirect in HOLD together with ready, unaligned target.
        rv_fix       = 0;
        rdata_fix_en = 0;
        do_reset(0);
        wait_present();
        cycle(1, 32'h0000_0203, 1);
        cycle(0, '0, 0);
        chk("t4_req", imem_req, 1);

        // Delayed grant keeps the address stable.
        gnt_fix = 3;
        do_reset(0);
        for (int n = 0; n < 4; n++) begin
            cycle(0, '0, 0);
            chk("t5_req", imem_req, 1);
            chk("t5_addr", imem_addr, RST_PC);
        end
        cycle(0, '0, 0);
        chk("t5_wait_req", imem_req, 0);

        // Reset during WAIT, stale rvalid after release.
        gnt_fix = 0;
        rv_fix  = 2;
        do_reset(0);
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        rv_fix = 0;
        do_reset(1);
        wait_present();
        cycle(0, '0, 1);

        // PC wrap from 0xFFFF_FFFC.
        do_reset(0);
        wait_present();
        cycle(1, 32'hFFFF_FFFE, 0);
        wait_present();
        cycle(0, '0, 0);
        chk("t7_instr_pc", instr_pc, 32'hFFFF_FFFC);
        cycle(0, '0, 1);
        cycle(0, '0, 0);

        // Randomized traffic: latencies, redirects, backpressure, stray rvalid.
        gnt_fix = -1;
        rv_fix  = -1;
        spur_en = 1;
        do_reset(0);
        for (int n = 0; n < 3000; n++) begin
            bit          br;
            logic [31:0] tgt;
            br  = ($urandom_range(7, 0) == 0);
            tgt = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFC : $urandom;
            cycle(br, tgt, bit'($urandom_range(1, 0)));
        end

        gnt_fix = 0;
        rv_fix  = 0;
        spur_en = 0;
        for (int n = 0; n < 20; n++) cycle(0, '0, 1);
        chk("drain_instr_q", q_instr.size(), 0);
        chk("drain_addr_q", (q_addr.size() <= 1), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage directly upstream of the single-cycle control unit. Holds the program counter and issues one word-aligned request at a time to instruction memory. It latches the returned word and presents it, with its 7-bit opcode field, to decode/control through a valid/ready handshake. Redirects from the branch-resolution logic are handled here, including killing a fetch that is already in flight.

## Interface
- XLEN, 32, address and instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  XLEN  fetch address; always equal to pc; bits [1:0] always 0.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid this cycle.
- imem_rdata  in  XLEN  returned instruction word.
- instr_valid  out  1  instr/instr_pc/opcode hold a valid instruction.
- instr_ready  in  1  decode consumes the instruction this cycle.
- instr  out  XLEN  latched instruction word.
- instr_pc  out  XLEN  address of instr.
- opcode  out  7  instr[6:0], fed to the control unit's Instruction_Opcode.
- branch_taken  in  1  single-cycle redirect pulse.
- branch_target  in  XLEN  redirect address; bits [1:0] ignored and forced to 0.

## Operation
- FSM states: IDLE, FETCH, WAIT, HOLD.
- IDLE: entered only on reset. Moves to FETCH on the next edge unconditionally.
- FETCH: imem_req=1. imem_addr stays stable until imem_gnt. On gnt, go to WAIT.
- WAIT: imem_req=0.
  - On imem_rvalid with kill=0: instr<=imem_rdata, instr_pc<=pc, go to HOLD.
  - On imem_rvalid with kill=1: discard the data, pc<=redirect_pc, kill<=0, go to FETCH.
- HOLD: instr_valid=1.
  - On instr_ready: pc<=pc+4 (modulo 2^XLEN), go to FETCH.
- Redirect (branch_taken=1):
  - In HOLD: pc<=target, go to FETCH. If instr_ready is high in the same cycle, the transfer still completes, but the redirect wins for the next PC.
  - In FETCH before gnt, or in FETCH with gnt, or in WAIT: redirect_pc<=target, kill<=1. The in-flight request runs to completion and is discarded.
  - In WAIT, if rvalid arrives in the same cycle as the redirect, the data is discarded and pc<=target directly.
  - A later redirect overwrites an earlier pending redirect_pc.
  - In IDLE: ignored.
- Only one outstanding request at a time. imem_rvalid outside WAIT is ignored.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, redirect_pc=0, kill=0.
  - instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, opcode=7'b0010011.
  - instr_valid=0, imem_req=0.
- Reset asserted mid-fetch forces the reset values immediately. An rvalid that arrives after reset is released, from the aborted fetch, is ignored because the FSM is not in WAIT.
- First request: imem_req rises one cycle after reset release.
- Zero-wait memory (gnt in the same cycle as req, rvalid on the next cycle): instr_valid rises 2 cycles after req.
- Sustained throughput with instr_ready tied high is one instruction per 3 cycles (FETCH, WAIT, HOLD).
- imem_req and instr_valid are decoded from the state register only; there is no combinational path from inputs.

## Structure
- Shared package rv_pkg holds:
  - the opcode constants (R-type 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011, OP-IMM 0010011);
  - the NOP constant 32'h0000_0013;
  - the fetch FSM state encoding.
- One sub-module is natural: ifetch_pc_reg, containing pc, redirect_pc and kill with next-PC select (RESET_PC / pc+4 / target). The FSM and instruction latch stay in the top module.

## Test plan
- Reset release, memory always grants with rvalid one cycle later, instr_ready=1, imem_rdata=32'h00A00093 → imem_addr sequence 0x0, 0x4, 0x8; opcode=0010011; each instr_valid pulse is 3 cycles apart.
- Backpressure: instr_ready=0 for 4 cycles in HOLD → instr and instr_pc remain stable and no new imem_req is issued; on the ready cycle, the next imem_addr is pc+4.
- Redirect during WAIT to 0x100 with late rvalid carrying 32'h00000033 → data discarded, instr_valid stays 0, next imem_addr=0x100.
- Redirect in HOLD at the same time as instr_ready, target 0x203 → transfer completes and next imem_addr=0x200.
- imem_gnt delayed 3 cycles → imem_addr held constant while imem_req=1.
- Reset asserted during WAIT → all outputs take reset values at once; the stale rvalid after release is ignored, and the first new fetch is to RESET_PC.
- PC wrap: pc=32'hFFFF_FFFC, instruction accepted → next imem_addr=0x0.
